pmp_dmp_checker: RTL and testbench

Pipelined, parametrised successor to the combinational PMP/DMP permission check. One request channel with valid/ready handshake and two register stages: entry match, then priority resolve with access and domain check. Adds a configurable entry count (up to 64), tagged responses, flush-and-retry on configuration update, and a sticky first-fault capture with a saturating violation counter. Sits between the LSU/PTW request path and the memory interface.

---
 rtl/pmp_dmp_checker.sv | 230 +++++++++++++++++++++++
 tb/tb_pmp_dmp_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_dmp_checker.sv
// Two-stage pipelined PMP/DMP permission checker: S1 registers the request and entry match
// vector, S2 resolves priority, access and domain, and tags the response.
module pmp_dmp_checker #(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned DOM_W      = 4,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic                                                 req_valid_i,
  output logic                                                 req_ready_o,
  input  logic [PLEN-1:0]                                      req_addr_i,
  input  logic [2:0]                                           req_access_i,
  input  logic [1:0]                                           req_priv_i,
  input  logic [DOM_W-1:0]                                     req_dom_i,
  input  logic [ID_W-1:0]                                      req_id_i,
  input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)*PMP_LEN-1:0] conf_addr_i,
  input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)*8-1:0]       pmpconf_i,
  input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)*(DOM_W+1)-1:0] dmpconf_i,
  input  logic                                                 cfg_update_i,
  output logic                                                 resp_valid_o,
  input  logic                                                 resp_ready_i,
  output logic [ID_W-1:0]                                      resp_id_o,
  output logic                                                 resp_allow_o,
  output logic                                                 resp_retry_o,
  output logic [6:0]                                           resp_entry_o,
  output logic                                                 resp_dom_fault_o,
  output logic                                                 fault_valid_o,
  output logic [PLEN-1:0]                                      fault_addr_o,
  input  logic                                                 fault_clear_i,
  output logic [CNT_W-1:0]                                     fault_count_o
);
  localparam int unsigned NE = (NR_ENTRIES > 0) ? NR_ENTRIES : 1;
  localparam int unsigned DW = DOM_W + 1;
  localparam logic [6:0] NoMatch = 7'd127;

  logic unused_bits;
  assign unused_bits = ^req_addr_i[1:0] ^ ^pmpconf_i;

  // Entry match (combinational, S1 input side)
  logic [PMP_LEN-1:0] word_addr, cur, prev, mask;
  logic [NE-1:0]      match;
  assign word_addr = PMP_LEN'(req_addr_i[PLEN-1:2]);

  always_comb begin
    match = '0;
    cur   = '0;
    prev  = '0;
    mask  = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      cur  = conf_addr_i[i*PMP_LEN +: PMP_LEN];
      // NAPOT: trailing ones plus the first zero bit form the don't-care mask
      mask = cur ^ (cur + PMP_LEN'(1));
      case (pmpconf_i[i*8+3 +: 2])
        2'd1:    match[i] = (word_addr >= prev) && (word_addr < cur);
        2'd2:    match[i] = (word_addr == cur);
        2'd3:    match[i] = ((word_addr & ~mask) == (cur & ~mask));
        default: match[i] = 1'b0;
      endcase
      prev = cur;
    end
  end

  // Per-entry {L, X, W, R} snapshot of pmpcfg taken with the request
  logic [NE*4-1:0] pmp_snap;
  always_comb begin
    pmp_snap = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      pmp_snap[i*4 +: 4] = {pmpconf_i[i*8+7], pmpconf_i[i*8 +: 3]};
    end
  end

  // Handshake
  logic s1_valid_q, s1_retry_q, s2_adv, s1_load, resp_valid_q;
  assign s2_adv      = !resp_valid_q || resp_ready_i;
  assign req_ready_o = (!s1_valid_q || s2_adv) && !cfg_update_i;
  assign s1_load     = req_valid_i && req_ready_o;

  // Stage 1 registers
  logic [PLEN-1:0]  s1_addr_q;
  logic [2:0]       s1_access_q;
  logic [1:0]       s1_priv_q;
  logic [DOM_W-1:0] s1_dom_q;
  logic [ID_W-1:0]  s1_id_q;
  logic [NE-1:0]    s1_match_q;
  logic [NE*4-1:0]  s1_pmp_q;
  logic [NE*DW-1:0] s1_dmp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_retry_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_access_q <= '0;
      s1_priv_q   <= '0;
      s1_dom_q    <= '0;
      s1_id_q     <= '0;
      s1_match_q  <= '0;
      s1_pmp_q    <= '0;
      s1_dmp_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q  <= 1'b1;
      s1_retry_q  <= 1'b0;
      s1_addr_q   <= req_addr_i;
      s1_access_q <= req_access_i;
      s1_priv_q   <= req_priv_i;
      s1_dom_q    <= req_dom_i;
      s1_id_q     <= req_id_i;
      s1_match_q  <= match;
      s1_pmp_q    <= pmp_snap;
      s1_dmp_q    <= dmpconf_i;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
      s1_retry_q <= 1'b0;
    end else if (cfg_update_i && s1_valid_q) begin
      s1_retry_q <= 1'b1;
    end
  end

  // Priority resolve and access/domain check (S2 input side)
  logic             hit, perm_ok, dom_ok;
  logic [6:0]       hit_idx;
  logic [2:0]       hit_perm;
  logic [DOM_W-1:0] hit_dom;
  logic             allow_d, dom_fault_d, retry_d;
  logic [6:0]       entry_d;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = NoMatch;
    hit_perm = '0;
    hit_dom  = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (!hit && s1_match_q[i] &&
          (s1_priv_q != 2'd3 || (s1_pmp_q[i*4+3] && s1_dmp_q[i*DW+DOM_W]))) begin
        hit      = 1'b1;
        hit_idx  = 7'(i);
        hit_perm = s1_pmp_q[i*4 +: 3];
        hit_dom  = s1_dmp_q[i*DW +: DOM_W];
      end
    end
    perm_ok     = (s1_access_q & hit_perm) == s1_access_q;
    dom_ok      = (hit_dom == '0) || (s1_dom_q == '0) || (hit_dom == s1_dom_q);
    retry_d     = s1_retry_q || cfg_update_i;
    allow_d     = 1'b0;
    dom_fault_d = 1'b0;
    entry_d     = NoMatch;
    if (!retry_d) begin
      if (hit) begin
        allow_d     = perm_ok && dom_ok;
        dom_fault_d = perm_ok && !dom_ok;
        entry_d     = hit_idx;
      end else begin
        allow_d = (s1_priv_q == 2'd3);
      end
    end
  end

  // Stage 2 registers
  logic [ID_W-1:0] resp_id_q;
  logic            resp_allow_q, resp_retry_q, resp_dom_fault_q;
  logic [6:0]      resp_entry_q;
  logic [PLEN-1:0] resp_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q     <= 1'b0;
      resp_id_q        <= '0;
      resp_allow_q     <= 1'b0;
      resp_retry_q     <= 1'b0;
      resp_entry_q     <= NoMatch;
      resp_dom_fault_q <= 1'b0;
      resp_addr_q      <= '0;
    end else if (s2_adv) begin
      resp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        resp_id_q        <= s1_id_q;
        resp_allow_q     <= allow_d;
        resp_retry_q     <= retry_d;
        resp_entry_q     <= entry_d;
        resp_dom_fault_q <= dom_fault_d;
        resp_addr_q      <= s1_addr_q;
      end
    end else if (cfg_update_i) begin
      // Stalled response is invalidated in place
      resp_allow_q     <= 1'b0;
      resp_retry_q     <= 1'b1;
      resp_entry_q     <= NoMatch;
      resp_dom_fault_q <= 1'b0;
    end
  end

  // Sticky first-fault record and saturating counter
  logic            fault_valid_q, new_fault;
  logic [PLEN-1:0] fault_addr_q;
  logic [CNT_W-1:0] fault_count_q;
  assign new_fault = resp_valid_q && resp_ready_i && !resp_allow_q && !resp_retry_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_count_q <= '0;
    end else if (fault_clear_i) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_count_q <= '0;
    end else if (new_fault) begin
      if (fault_count_q != '1) fault_count_q <= fault_count_q + CNT_W'(1);
      if (!fault_valid_q) begin
        fault_valid_q <= 1'b1;
        fault_addr_q  <= resp_addr_q;
      end
    end
  end

  assign resp_valid_o     = resp_valid_q;
  assign resp_id_o        = resp_id_q;
  assign resp_allow_o     = resp_allow_q;
  assign resp_retry_o     = resp_retry_q;
  assign resp_entry_o     = resp_entry_q;
  assign resp_dom_fault_o = resp_dom_fault_q;
  assign fault_valid_o    = fault_valid_q;
  assign fault_addr_o     = fault_addr_q;
  assign fault_count_o    = fault_count_q;

endmodule

// File: tb/tb_pmp_dmp_checker.sv
// Scoreboard bench for pmp_dmp_checker: directed requests push expected responses, a monitor
// pops and compares on every response handshake.
module tb_pmp_dmp_checker;
  localparam int unsigned PLEN = 34, PMP_LEN = 32, NE = 16, DOM_W = 4, ID_W = 4, CNT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [PLEN-1:0] req_addr = '0;
  logic [2:0] req_access = '0;
  logic [1:0] req_priv = '0;
  logic [DOM_W-1:0] req_dom = '0;
  logic [ID_W-1:0] req_id = '0;
  logic [NE*PMP_LEN-1:0] conf_addr = '0;
  logic [NE*8-1:0] pmpconf = '0;
  logic [NE*(DOM_W+1)-1:0] dmpconf = '0;
  logic cfg_update = 1'b0, resp_valid, resp_ready = 1'b1;
  logic [ID_W-1:0] resp_id;
  logic resp_allow, resp_retry, resp_dom_fault, fault_valid, fault_clear = 1'b0;
  logic [6:0] resp_entry;
  logic [PLEN-1:0] fault_addr;
  logic [CNT_W-1:0] fault_count;

  pmp_dmp_checker dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_access_i(req_access), .req_priv_i(req_priv),
    .req_dom_i(req_dom), .req_id_i(req_id), .conf_addr_i(conf_addr), .pmpconf_i(pmpconf),
    .dmpconf_i(dmpconf), .cfg_update_i(cfg_update), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_id_o(resp_id), .resp_allow_o(resp_allow),
    .resp_retry_o(resp_retry), .resp_entry_o(resp_entry), .resp_dom_fault_o(resp_dom_fault),
    .fault_valid_o(fault_valid), .fault_addr_o(fault_addr), .fault_clear_i(fault_clear),
    .fault_count_o(fault_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ID_W-1:0] id;
    logic allow, retry, df;
    logic [6:0] entry;
    int acc;
    bit lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int errors = 0, checks = 0;
  bit lat_on = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every handshaken response against the head of the queue
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got id=%0d expected no response", resp_id);
      end else begin
        e = exp_q.pop_front();
        if (resp_id !== e.id || resp_allow !== e.allow || resp_retry !== e.retry ||
            resp_entry !== e.entry || resp_dom_fault !== e.df) begin
          errors++;
          $display("FAIL resp: got id=%0d allow=%0d retry=%0d entry=%0d df=%0d expected id=%0d allow=%0d retry=%0d entry=%0d df=%0d",
                   resp_id, resp_allow, resp_retry, resp_entry, resp_dom_fault,
                   e.id, e.allow, e.retry, e.entry, e.df);
        end
        if (e.lat) begin
          checks++;
          if (cyc != e.acc + 2) begin
            errors++;
            $display("FAIL latency id=%0d: got %0d cycles expected 2", e.id, cyc - e.acc);
          end
        end
      end
    end
  end

  // Drive a request (called at posedge+1); returns at posedge+1 after acceptance, valid left high
  task automatic issue(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic [1:0] pv,
                       input logic [DOM_W-1:0] d, input logic [ID_W-1:0] id, input logic al,
                       input logic rt, input logic [6:0] en, input logic df);
    exp_t x;
    bit done = 1'b0;
    req_valid = 1'b1; req_addr = a; req_access = acc; req_priv = pv; req_dom = d; req_id = id;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        x.id = id; x.allow = al; x.retry = rt; x.entry = en; x.df = df;
        x.acc = cyc; x.lat = lat_on;
        exp_q.push_back(x);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL accept_timeout id=%0d: got no acceptance expected req_ready", id);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  initial begin
    conf_addr[0*32 +: 32] = 32'h0000_0400;  // TOR 0..0x1000
    conf_addr[2*32 +: 32] = 32'h2000_01FF;  // NAPOT 0x8000_0000 4KiB
    conf_addr[3*32 +: 32] = 32'h0000_1000;  // NA4 0x4000
    conf_addr[4*32 +: 32] = 32'h0000_1400;  // NA4 0x5000
    pmpconf[0*8 +: 8] = 8'h0B;
    pmpconf[2*8 +: 8] = 8'h19;
    pmpconf[3*8 +: 8] = 8'h91;
    pmpconf[4*8 +: 8] = 8'h91;
    dmpconf[2*5 +: 5] = 5'b0_0101;
    dmpconf[4*5 +: 5] = 5'b1_0000;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp", 64'({resp_valid, resp_allow, resp_retry, resp_dom_fault}), 64'd0);
    chk("rst_id_entry", 64'({resp_id, resp_entry}), 64'({4'd0, 7'd127}));
    chk("rst_fault", 64'({fault_valid, fault_addr, fault_count}), 64'd0);
    @(posedge clk); #1;

    // Directed single requests: addr, access, priv, dom, id, allow, retry, entry, dom_fault
    issue(34'h0_0000_0800, 3'b001, 2'd0, 4'd3, 4'd1, 1, 0, 7'd0,   0); idle(3);
    issue(34'h0_8000_0010, 3'b001, 2'd0, 4'd6, 4'd2, 0, 0, 7'd2,   1); idle(3);
    chk("fault_addr_first", 64'(fault_addr), 64'h8000_0010);
    chk("fault_count_1", 64'(fault_count), 64'd1);
    issue(34'h0_8000_0010, 3'b001, 2'd0, 4'd0, 4'd3, 1, 0, 7'd2,   0); idle(3);
    issue(34'h0_8000_0010, 3'b010, 2'd0, 4'd0, 4'd4, 0, 0, 7'd2,   0); idle(3);
    chk("fault_count_2", 64'(fault_count), 64'd2);
    issue(34'h0_0000_4000, 3'b010, 2'd3, 4'd0, 4'd5, 1, 0, 7'd127, 0); idle(3);
    issue(34'h0_0000_5000, 3'b010, 2'd3, 4'd0, 4'd6, 0, 0, 7'd4,   0); idle(3);
    issue(34'h0_0000_1000, 3'b001, 2'd0, 4'd0, 4'd7, 0, 0, 7'd127, 0); idle(3);
    issue(34'h0_0000_0FFC, 3'b001, 2'd0, 4'd0, 4'd8, 1, 0, 7'd0,   0); drain();
    chk("fault_valid", 64'(fault_valid), 64'd1);
    chk("fault_addr_sticky", 64'(fault_addr), 64'h8000_0010);
    chk("fault_count_4", 64'(fault_count), 64'd4);

    // Back-to-back stream with a 3-cycle response stall
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue((i % 2) ? 34'h0_0000_0FFC : 34'h0_0000_0800, 3'b001, 2'd0, 4'd0,
                4'(i), 1, 0, 7'd0, 0);
        req_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 resp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("ready_low_full", 64'(req_ready), 64'd0);
          @(posedge clk); #1;
        end
        resp_ready = 1'b1;
      end
    join
    drain();
    chk("count_after_stream", 64'(fault_count), 64'd4);

    // cfg update on an empty pipeline blocks acceptance that cycle only
    cfg_update = 1'b1;
    @(negedge clk); chk("ready_cfg_update", 64'(req_ready), 64'd0);
    @(posedge clk); #1 cfg_update = 1'b0;
    @(negedge clk); chk("ready_after_cfg", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Two requests in flight (response stalled) get flushed by cfg update
    resp_ready = 1'b0;
    issue(34'h0_8000_0010, 3'b001, 2'd0, 4'd6, 4'd9,  0, 1, 7'd127, 0);
    issue(34'h0_8000_0010, 3'b001, 2'd0, 4'd6, 4'd10, 0, 1, 7'd127, 0);
    req_valid = 1'b0;
    cfg_update = 1'b1;
    @(negedge clk); chk("ready_cfg_inflight", 64'(req_ready), 64'd0);
    @(posedge clk); #1 cfg_update = 1'b0; resp_ready = 1'b1;
    drain();
    chk("count_after_retry", 64'(fault_count), 64'd4);

    // Clear coincident with a new fault: clear wins
    lat_on = 1'b1;
    issue(34'h0_9000_0000, 3'b001, 2'd0, 4'd0, 4'd11, 0, 0, 7'd127, 0);
    idle(1);
    fault_clear = 1'b1;
    @(posedge clk); #1 fault_clear = 1'b0;
    drain();
    chk("clear_valid", 64'(fault_valid), 64'd0);
    chk("clear_count", 64'(fault_count), 64'd0);
    chk("clear_addr", 64'(fault_addr), 64'd0);

    issue(34'h0_9000_0004, 3'b001, 2'd0, 4'd0, 4'd12, 0, 0, 7'd127, 0);
    drain();
    chk("recapture_addr", 64'(fault_addr), 64'h9000_0004);
    chk("recapture_count", 64'(fault_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end
endmodule
